bf16_to_int: RTL

- Multi-cycle converter from bfloat16 (upper 16 bits of IEEE-754 single) to signed 16-bit two's-complement integer.
- Rounds toward zero, like a C cast.
- Uses the same clock/nreset/ready style as the fadd unit and sits on its output side, turning fadd sums back into integers for control/readout logic.
- Magnitude alignment is iterative, one bit per cycle, so area stays small.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/bf16_classify.sv | 28 ++
 rtl/bf16_to_int.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared bfloat16 types, constants and converter states
// Shared by bf16_to_int and the fadd unit; no ports.
package fp_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    localparam int BF16_BIAS    = 127;
    localparam int BF16_EXP_MAX = 255;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

endpackage

// File: rtl/bf16_classify.sv
// rtl/bf16_classify.sv - combinational classification of a bfloat16 operand
// Ports:
//   exp      in   biased exponent field
//   frac     in   fraction field
//   is_zero  out  exponent field is 0 (zero or denormal)
//   is_nan   out  exponent all ones, fraction nonzero
//   is_inf   out  exponent all ones, fraction zero
//   exp_unb  out  signed unbiased exponent (exp - bias)
module bf16_classify
    import fp_pkg::*;
(
    input  logic [7:0]        exp,
    input  logic [6:0]        frac,
    output logic              is_zero,
    output logic              is_nan,
    output logic              is_inf,
    output logic signed [9:0] exp_unb
);

    logic exp_max;

    assign exp_max = (exp == 8'(BF16_EXP_MAX));
    assign is_zero = (exp == 8'd0);
    assign is_nan  = exp_max && (frac != 7'd0);
    assign is_inf  = exp_max && (frac == 7'd0);
    assign exp_unb = $signed({2'b00, exp}) - $signed(10'(BF16_BIAS));

endmodule

// File: rtl/bf16_to_int.sv
// rtl/bf16_to_int.sv - multi-cycle bfloat16 to int16 converter, truncating
// Ports:
//   clock    in   rising-edge clock
//   nreset   in   synchronous active-low reset
//   start    in   begin conversion of a (accepted only while ready)
//   a        in   bfloat16 operand
//   result   out  signed 16-bit result, valid while ready
//   ready    out  1 = idle / result valid, 0 = busy
//   inexact  out  nonzero fraction bits were discarded
//   invalid  out  NaN, infinity or out of int16 range
module bf16_to_int
    import fp_pkg::*;
#(
    parameter bit SAT_EN = 1'b1
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        start,
    input  logic [15:0] a,
    output logic [15:0] result,
    output logic        ready,
    output logic        inexact,
    output logic        invalid
);

    bf16_t              op;
    logic               is_zero;
    logic               is_nan;
    logic               is_inf;
    logic signed [9:0]  exp_unb;

    state_t             state;
    state_t             state_next;

    logic               sign_q;
    logic [15:0]        mag_q;
    logic [2:0]         cnt_q;
    logic               left_q;
    logic               sticky_q;
    logic               inv_q;
    logic               accept;

    assign op     = bf16_t'(a);
    assign ready  = (state == IDLE);
    assign accept = ready && start;

    bf16_classify u_classify (
        .exp     (op.exp),
        .frac    (op.frac),
        .is_zero (is_zero),
        .is_nan  (is_nan),
        .is_inf  (is_inf),
        .exp_unb (exp_unb)
    );

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every accepted operand spends at least one cycle in SHIFT (even with a
    // zero count), so ready returns exactly 2+k edges after the start edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_q == 3'd0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            sign_q   <= 1'b0;
            mag_q    <= 16'd0;
            cnt_q    <= 3'd0;
            left_q   <= 1'b0;
            sticky_q <= 1'b0;
            inv_q    <= 1'b0;
            result   <= 16'd0;
            inexact  <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            if (accept) begin
                sign_q   <= op.sign;
                mag_q    <= {8'd0, 1'b1, op.frac};
                cnt_q    <= 3'd0;
                left_q   <= 1'b0;
                sticky_q <= 1'b0;
                inv_q    <= 1'b0;
                // Special cases preload the final magnitude so FINISH needs
                // no separate path: sign-applied 0x8000 stays 0x8000.
                if (is_nan) begin
                    mag_q <= 16'd0;
                    inv_q <= 1'b1;
                end else if (is_inf || exp_unb >= 10'sd15) begin
                    if (op.sign && exp_unb == 10'sd15 && op.frac == 7'd0) begin
                        mag_q <= 16'h8000;
                    end else begin
                        inv_q <= 1'b1;
                        if (SAT_EN) begin
                            mag_q <= op.sign ? 16'h8000 : 16'h7FFF;
                        end else begin
                            mag_q <= 16'd0;
                        end
                    end
                end else if (is_zero) begin
                    mag_q    <= 16'd0;
                    sticky_q <= (op.frac != 7'd0);
                end else if (exp_unb < 10'sd0) begin
                    mag_q    <= 16'd0;
                    sticky_q <= 1'b1;
                end else if (exp_unb <= 10'sd6) begin
                    cnt_q <= 3'd7 - exp_unb[2:0];
                end else begin
                    // e in 7..14: e-7 equals the low three bits plus one, mod 8.
                    left_q <= 1'b1;
                    cnt_q  <= exp_unb[2:0] + 3'd1;
                end
            end

            if (state == SHIFT && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
                if (left_q) begin
                    mag_q <= {mag_q[14:0], 1'b0};
                end else begin
                    mag_q    <= {1'b0, mag_q[15:1]};
                    sticky_q <= sticky_q | mag_q[0];
                end
            end

            if (state == FINISH) begin
                result  <= sign_q ? (16'd0 - mag_q) : mag_q;
                inexact <= sticky_q;
                invalid <= inv_q;
            end
        end
    end

endmodule
